// File: rtl/bit_sync_filt.sv
// Multi-bit level synchroniser with a per-bit persistence filter and registered edge pulses.
// Each bit is an independent channel; no coherency is implied across bits.
`timescale 1ns/1ps
module bit_sync_filt #(
  parameter int                   NUM_STAGES = 2,
  parameter int                   BUS_WIDTH  = 1,
  parameter int                   FILTER_LEN = 1,
  parameter logic [BUS_WIDTH-1:0] RST_VAL    = {BUS_WIDTH{1'b0}}
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic [BUS_WIDTH-1:0] RISE,
  output logic [BUS_WIDTH-1:0] FALL,
  output logic                 ANY_EDGE
);

  localparam int               CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [BUS_WIDTH-1:0] stage_reg [NUM_STAGES];
  logic [BUS_WIDTH-1:0] raw;
  logic [BUS_WIDTH-1:0] update_next;
  logic [BUS_WIDTH-1:0] sync_reg;
  logic [BUS_WIDTH-1:0] rise_reg;
  logic [BUS_WIDTH-1:0] fall_reg;
  logic                 any_edge_reg;

  // Pure flop chain: metastability is confined to stage 0, nothing sits between stages.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stage_reg[k] <= RST_VAL;
      end
    end else begin
      stage_reg[0] <= ASYNC;
      for (int k = 1; k < NUM_STAGES; k++) begin
        stage_reg[k] <= stage_reg[k-1];
      end
    end
  end

  assign raw = stage_reg[NUM_STAGES-1];

  generate
    for (genvar gi = 0; gi < BUS_WIDTH; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             upd;

      // Counts consecutive mismatch cycles; any agreement restarts the count.
      always_comb begin
        cnt_next = cnt_reg;
        upd      = 1'b0;
        if (raw[gi] == sync_reg[gi]) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
          upd      = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign update_next[gi] = upd;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_reg     <= RST_VAL;
      rise_reg     <= '0;
      fall_reg     <= '0;
      any_edge_reg <= 1'b0;
    end else begin
      sync_reg     <= (sync_reg & ~update_next) | (raw & update_next);
      rise_reg     <= update_next & raw;
      fall_reg     <= update_next & ~raw;
      any_edge_reg <= |update_next;
    end
  end

  assign SYNC     = sync_reg;
  assign RISE     = rise_reg;
  assign FALL     = fall_reg;
  assign ANY_EDGE = any_edge_reg;

endmodule

// File: tb/tb_bit_sync_filt.sv
// Scoreboarded bench for bit_sync_filt: a filtered instance and an unfiltered instance
// share one ASYNC stimulus and are checked against a sliding-window reference model.
`timescale 1ns/1ps
module tb_bit_sync_filt;

  localparam int         NS   = 2;
  localparam int         FL_A = 3;
  localparam int         FL_B = 1;
  localparam logic [3:0] RV_A = 4'b0101;
  localparam logic [3:0] RV_B = 4'b0000;

  logic       CLK   = 1'b0;
  logic       RST   = 1'b1;
  logic [3:0] ASYNC = 4'b1111;
  logic [3:0] sync_a, rise_a, fall_a;
  logic [3:0] sync_b, rise_b, fall_b;
  logic       any_a, any_b;

  always #5 CLK = ~CLK;

  bit_sync_filt #(.NUM_STAGES(NS), .BUS_WIDTH(4), .FILTER_LEN(FL_A), .RST_VAL(RV_A)) dut_a (
    .CLK(CLK), .RST(RST), .ASYNC(ASYNC),
    .SYNC(sync_a), .RISE(rise_a), .FALL(fall_a), .ANY_EDGE(any_a)
  );

  bit_sync_filt #(.NUM_STAGES(NS), .BUS_WIDTH(4), .FILTER_LEN(FL_B), .RST_VAL(RV_B)) dut_b (
    .CLK(CLK), .RST(RST), .ASYNC(ASYNC),
    .SYNC(sync_b), .RISE(rise_b), .FALL(fall_b), .ANY_EDGE(any_b)
  );

  typedef struct packed {
    logic [3:0] sa; logic [3:0] ra; logic [3:0] fa; logic aa;
    logic [3:0] sb; logic [3:0] rb; logic [3:0] fb; logic ab;
  } exp_t;

  exp_t       sb_q [$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  bit         model_on = 1'b0;
  logic [3:0] hist_a [8];
  logic [3:0] hist_b [8];
  logic [3:0] m_sync_a, m_sync_b;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // h[0] is the newest ASYNC sample; the value raw presents just before an edge is h[NS-1].
  // A bit updates when every sample in the last fl raw cycles differs from the current level.
  function automatic logic [3:0] win_upd(input logic [3:0] h [8], input int fl, input logic [3:0] s);
    logic [3:0] u;
    u = 4'b1111;
    for (int k = NS - 1; k < NS - 1 + fl; k++) u = u & (h[k] ^ s);
    return u;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      hist_a[k] = RV_A;
      hist_b[k] = RV_B;
    end
    m_sync_a = RV_A;
    m_sync_b = RV_B;
  endtask

  // Apply one input for the coming rising edge and queue what both DUTs must show after it.
  task automatic drive(input logic [3:0] a);
    exp_t       e;
    logic [3:0] ua, ub, ra, rb;
    ASYNC = a;
    if (model_on) begin
      ua = win_upd(hist_a, FL_A, m_sync_a);
      ub = win_upd(hist_b, FL_B, m_sync_b);
      ra = hist_a[NS-1];
      rb = hist_b[NS-1];
      m_sync_a = (m_sync_a & ~ua) | (ra & ua);
      m_sync_b = (m_sync_b & ~ub) | (rb & ub);
      e.sa = m_sync_a; e.ra = ua & ra; e.fa = ua & ~ra; e.aa = |ua;
      e.sb = m_sync_b; e.rb = ub & rb; e.fb = ub & ~rb; e.ab = |ub;
      for (int k = 7; k > 0; k--) begin
        hist_a[k] = hist_a[k-1];
        hist_b[k] = hist_b[k-1];
      end
      hist_a[0] = a;
      hist_b[0] = a;
      sb_q.push_back(e);
    end
    @(negedge CLK);
  endtask

  always @(posedge CLK) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("sync_a", sync_a, mon_e.sa);
      chk("rise_a", rise_a, mon_e.ra);
      chk("fall_a", fall_a, mon_e.fa);
      chk("any_a", {3'b000, any_a}, {3'b000, mon_e.aa});
      chk("sync_b", sync_b, mon_e.sb);
      chk("rise_b", rise_b, mon_e.rb);
      chk("fall_b", fall_b, mon_e.fb);
      chk("any_b", {3'b000, any_b}, {3'b000, mon_e.ab});
      chk("rf_excl_a", rise_a & fall_a, 4'b0000);
      chk("rf_excl_b", rise_b & fall_b, 4'b0000);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] cur;
    logic       seen;
    int         rise_at, fall_at, any_cnt, hit;

    // Asynchronous reset in the middle of a cycle.
    #7 RST = 1'b0;
    #1;
    chk("rst_sync_a", sync_a, RV_A);
    chk("rst_rise_a", rise_a, 4'b0000);
    chk("rst_fall_a", fall_a, 4'b0000);
    chk("rst_any_a", {3'b000, any_a}, 4'b0000);
    chk("rst_sync_b", sync_b, RV_B);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    model_on = 1'b1;

    // Release with ASYNC=1111: filtered instance updates at edge 5, unfiltered at edge 3.
    for (int k = 1; k <= 8; k++) begin
      drive(4'b1111);
      if (k == 2) chk("lat_b_e2_sync", {3'b000, sync_b[0]}, 4'b0000);
      if (k == 3) chk("lat_b_e3_sync_rise", {2'b00, sync_b[0], rise_b[0]}, 4'b0011);
      if (k == 4) chk("lat_b_e4_rise", {3'b000, rise_b[0]}, 4'b0000);
      if (k == 4) chk("rel_e4_sync_a", sync_a, RV_A);
      if (k == 5) chk("rel_e5_sync_a", sync_a, 4'b1111);
      if (k == 5) chk("rel_e5_rise_a", rise_a, 4'b1010);
      if (k == 5) chk("rel_e5_fall_a", fall_a, 4'b0000);
      if (k == 6) chk("rel_e6_rise_a", rise_a, 4'b0000);
    end

    // Glitch rejection on bit 2: a 2-cycle pulse must vanish.
    for (int k = 0; k < 8; k++) drive(4'b0000);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive((k < 2) ? 4'b0100 : 4'b0000);
      seen = seen | sync_a[2] | rise_a[2];
    end
    chk("glitch2_rejected", {3'b000, seen}, 4'b0000);

    // A 3-cycle pulse is accepted, with rise and fall 3 cycles apart.
    rise_at = -1; fall_at = -1; seen = 1'b0;
    for (int k = 0; k < 13; k++) begin
      drive((k < 3) ? 4'b0100 : 4'b0000);
      if (rise_a[2] && rise_at < 0) rise_at = k;
      if (fall_a[2] && fall_at < 0) fall_at = k;
      seen = seen | sync_a[2];
    end
    chk("pulse3_sync_seen", {3'b000, seen}, 4'b0001);
    chk_int("pulse3_rise_found", (rise_at >= 0) ? 1 : 0, 1);
    chk_int("pulse3_rise_fall_gap", fall_at - rise_at, 3);

    // Simultaneous transitions on all channels.
    for (int k = 0; k < 8; k++) drive(4'b0101);
    any_cnt = 0; hit = 0;
    for (int k = 0; k < 10; k++) begin
      drive(4'b1010);
      if (any_a) any_cnt++;
      if (any_a && rise_a == 4'b1010 && fall_a == 4'b0101) hit++;
    end
    chk_int("simul_any_pulses", any_cnt, 1);
    chk_int("simul_edge_hit", hit, 1);

    // Reset while bit 1 is two cycles into its filter.
    for (int k = 0; k < 8; k++) drive(4'b0101);
    for (int k = 0; k < 4; k++) drive(4'b0111);
    model_on = 1'b0;
    RST = 1'b0;
    #1;
    chk("midrst_sync_a", sync_a, RV_A);
    chk("midrst_rise_a", rise_a, 4'b0000);
    chk("midrst_fall_a", fall_a, 4'b0000);
    chk("midrst_sync_b", sync_b, RV_B);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    model_on = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive(4'b0111);
      if (k <= 4) seen = seen | (|rise_a) | (|fall_a);
      if (k == 4) chk("midrst_e4_sync_a", sync_a, RV_A);
      if (k == 5) chk("midrst_e5_sync_a", sync_a, 4'b0111);
      if (k == 5) chk("midrst_e5_rise_a", rise_a, 4'b0010);
    end
    chk("midrst_no_stale", {3'b000, seen}, 4'b0000);

    // Long random run; each bit flips with probability 1/4 per cycle.
    cur = ASYNC;
    for (int i = 0; i < 10000; i++) begin
      cur = cur ^ (4'($urandom) & 4'($urandom));
      drive(cur);
    end

    @(negedge CLK);
    chk_int("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_sync_filt.md
# bit_sync_filt

Parametrised multi-bit level synchroniser with per-bit glitch filter and edge-pulse outputs. It replaces the plain flop-chain bit synchroniser wherever a CLK-domain consumer needs either of these:
- a debounced level from an asynchronous or quasi-static source, such as a config strap, an external request line or a status flag from another domain;
- single-cycle rise and fall events without its own edge detector.

Each bit is an independent channel. No multi-bit coherency is provided, so buses needing coherent transfer use a handshake synchroniser.

## Interface
Parameters:
- NUM_STAGES, 2, synchroniser flops per bit; legal range ≥ 2.
- BUS_WIDTH, 1, number of independent channels; legal range ≥ 1.
- FILTER_LEN, 1, consecutive cycles a new synchronised value must persist before SYNC accepts it; legal range ≥ 1, and 1 means no filtering.
- RST_VAL, {BUS_WIDTH{1'b0}}, per-bit reset value of every chain stage and of SYNC.

Ports:
- CLK  input  1  sole clock; all flops are rising-edge.
- RST  input  1  asynchronous, active-low reset.
- ASYNC  input  BUS_WIDTH  asynchronous input levels.
- SYNC  output  BUS_WIDTH  filtered, synchronised level; registered.
- RISE  output  BUS_WIDTH  one-cycle pulse when SYNC[j] goes 0→1; registered.
- FALL  output  BUS_WIDTH  one-cycle pulse when SYNC[j] goes 1→0; registered.
- ANY_EDGE  output  1  registered OR-reduction of all next-cycle RISE|FALL bits, aligned with RISE/FALL.

## Operation
Each channel j has three parts.

**Chain**
- stage[j][0] <= ASYNC[j], and stage[j][k] <= stage[j][k-1] for k = 1..NUM_STAGES-1.
- raw[j] = stage[j][NUM_STAGES-1].
- No logic is allowed between chain flops.

**Filter counter**
- cnt[j] has width $clog2(FILTER_LEN) and a minimum of 1 bit.
- If raw[j] == SYNC[j]: cnt[j] <= 0.
- Else if cnt[j] == FILTER_LEN-1: update.
  - SYNC[j] <= raw[j].
  - cnt[j] <= 0.
- Else: cnt[j] <= cnt[j]+1.
- With FILTER_LEN = 1, every mismatch updates immediately, so SYNC is raw delayed one cycle.

**Edge outputs**
- RISE[j] <= update & raw[j].
- FALL[j] <= update & ~raw[j].
- ANY_EDGE <= |(next RISE | next FALL).
- In every cycle where no update occurs, these outputs are 0.

**Reset and boundary behaviour**
- Reset (RST low, asynchronous):
  - every chain stage and SYNC load RST_VAL;
  - cnt, RISE, FALL and ANY_EDGE go to 0.
- Release produces no pulse by itself. If ASYNC differs from RST_VAL after release, the normal path produces the transition and its pulse after full latency.
- Reset asserted mid-filter discards the count. Nothing partial survives.
- Glitch rejection: a raw excursion shorter than FILTER_LEN cycles never reaches SYNC and produces no pulse. The counter restarts from 0 on the next excursion, so excursions are not accumulated.
- Counter behaviour: cnt never exceeds FILTER_LEN-1 and needs no wrap handling.
- Channel independence: simultaneous transitions on several bits produce simultaneous pulses. ANY_EDGE shows one pulse for them.
- Same-cycle RISE and FALL on one bit is impossible by construction.

## Timing
- Latency: ASYNC stable before capture edge E1 appears on SYNC after edge E(NUM_STAGES+FILTER_LEN).
  - Defaults: edge E3.
  - NUM_STAGES=2, FILTER_LEN=3: edge E5.
- RISE, FALL and ANY_EDGE go high on the same edge that SYNC changes, and stay high for exactly one cycle.
- Minimum accepted level duration at raw is FILTER_LEN cycles. A level held for FILTER_LEN-1 cycles is rejected.
- Back-to-back accepted edges on one bit are at least FILTER_LEN cycles apart.
- Throughput: one transition per bit per FILTER_LEN cycles.
- Metastability is confined to stage[j][0]. The counter and outputs see only raw.

## Test plan
Configuration: NUM_STAGES=2, FILTER_LEN=3, BUS_WIDTH=4, RST_VAL=4'b0101 unless noted.
1. Reset values:
   - stimulus: assert RST low mid-cycle with ASYNC=4'b1111;
   - required: immediately SYNC=4'b0101 and RISE=FALL=0, ANY_EDGE=0;
   - required: after release, SYNC=4'b1111 at the 5th edge, with RISE=4'b1010 for one cycle and FALL=0.
2. Latency:
   - stimulus: with FILTER_LEN=1, drive ASYNC[0] 0→1 before edge E1;
   - required: SYNC[0]=1 and RISE[0]=1 after E3, RISE[0]=0 after E4.
3. Glitch rejection:
   - stimulus: ASYNC[2] from 0 to 1 for 2 cycles, then back to 0;
   - required: SYNC[2] stays 0 and RISE[2] never pulses;
   - stimulus: repeat with a 3-cycle pulse;
   - required: SYNC[2] goes 1 then back to 0, with RISE[2] and FALL[2] pulses exactly 3 cycles apart.
4. Simultaneous channels:
   - stimulus: ASYNC from 4'b0101 to 4'b1010 in one cycle;
   - required: on one edge, RISE=4'b1010, FALL=4'b0101 and ANY_EDGE=1, each for exactly one cycle.
5. Reset mid-filter:
   - stimulus: assert RST when cnt[1]=2;
   - required: after release, the full 5-edge latency is needed again and no stale pulse appears.
6. Random long run:
   - stimulus: 10k cycles of random ASYNC;
   - required checks, scoreboarded against a reference model:
     - SYNC equals the model;
     - RISE/FALL are never both high on one bit;
     - ANY_EDGE equals |(RISE|FALL).
